// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V fetch front end.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    // Canonical NOP: addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    // Clears the byte-offset bits of an address to make it word aligned
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2,
        IF_DROP = 2'd3
    } if_state_e;

endpackage

// File: rtl/if_out_buf.sv
// Single-entry fetch output buffer holding the PC/instruction handed to IF/ID.
module if_out_buf
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_load_pc,
    input  logic [ILEN-1:0] i_load_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [ILEN-1:0] o_instr,
    output logic            o_valid,
    output logic            o_free_c
);

    logic [XLEN-1:0] r_pc;
    logic [ILEN-1:0] r_instr;
    logic            r_valid;
    logic            w_consume;

    // Downstream takes the entry on every unstalled edge while it is valid
    assign w_consume = r_valid & ~i_stall;
    assign o_free_c  = ~r_valid | ~i_stall;

    // Flush beats load, load beats consume; otherwise hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= '0;
            r_instr <= NOP;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_pc    <= i_load_pc;
            r_instr <= i_load_instr;
            r_valid <= 1'b1;
        end else if (w_consume) begin
            r_instr <= NOP;
            r_valid <= 1'b0;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, redirect flush, output buffer.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] pc_o,
    output logic [ILEN-1:0] instr_o,
    output logic            valid_o
);

    if_state_e       r_state;
    if_state_e       w_next_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            w_buf_free;
    logic            w_req;
    logic            w_grant;
    logic            w_load;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IF_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: redirect wins; a response still in flight after a redirect is dropped
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IF_IDLE: w_next_state = IF_REQ;
            IF_REQ: begin
                if (redirect_i) begin
                    w_next_state = w_grant ? IF_DROP : IF_REQ;
                end else if (w_grant) begin
                    w_next_state = IF_WAIT;
                end
            end
            IF_WAIT: begin
                // A redirect coinciding with the response discards it here, nothing left to drop
                if (imem_rvalid_i) begin
                    w_next_state = IF_REQ;
                end else if (redirect_i) begin
                    w_next_state = IF_DROP;
                end
            end
            IF_DROP: begin
                if (imem_rvalid_i) begin
                    w_next_state = IF_REQ;
                end
            end
            default: w_next_state = IF_IDLE;
        endcase
    end

    // Outputs: request only when the buffer can accept the response
    always_comb begin
        w_req   = 1'b0;
        w_load  = 1'b0;
        case (r_state)
            IF_REQ:  w_req  = w_buf_free;
            IF_WAIT: w_load = imem_rvalid_i & ~redirect_i;
            default: ;
        endcase
        w_grant = w_req & imem_gnt_i;
    end

    // Fetch PC advances on grant; redirect overrides; granted address kept for the response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
        end else begin
            if (w_grant) begin
                r_req_pc <= r_fetch_pc;
            end
            if (redirect_i) begin
                r_fetch_pc <= redirect_pc_i & ALIGN_MASK;
            end else if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
        end
    end

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_fetch_pc;

    if_out_buf u_out_buf (
        .clk          (clk),
        .reset        (reset),
        .i_stall      (stall_i),
        .i_flush      (redirect_i),
        .i_load       (w_load),
        .i_load_pc    (r_req_pc),
        .i_load_instr (imem_rdata_i),
        .o_pc         (pc_o),
        .o_instr      (instr_o),
        .o_valid      (valid_o),
        .o_free_c     (w_buf_free)
    );

endmodule
